image_write_ctrl: RTL
=====================

Name: image_write_ctrl

Overview:
- Frame sequencer in front of the BMP image writer in the simulation output path.
- Accepts a valid/ready stream of RGB888 pixel pairs from the processing pipeline, and produces the writer's hsync strobe and six data bytes in raster order.
- Inserts programmable horizontal blanking between rows and supports start/abort of a frame.
- Reports busy, current row/column, and a one-cycle frame_done pulse.

Parameters:
- WIDTH, 768: image width in pixels; must be even; one beat carries 2 pixels.
- HEIGHT, 512: image height in rows.
- HBLANK, 160: idle cycles inserted after each row except the last; 0 is legal and means no gap.

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  reset, synchronous, active-low
- start  in  1  begin a frame; sampled only in IDLE
- abort  in  1  abandon the current frame
- in_valid  in  1  upstream pair valid
- in_ready  out  1  controller accepts a pair this cycle
- in_pix0  in  24  even pixel {R,G,B}
- in_pix1  in  24  odd pixel {R,G,B}
- hsync  out  1  writer strobe: one pixel pair is valid
- DATA_WRITE_R0/G0/B0  out  8 each  pixel 0 bytes to the writer
- DATA_WRITE_R1/G1/B1  out  8 each  pixel 1 bytes to the writer
- busy  out  1  high in every state except IDLE
- row_idx  out  $clog2(HEIGHT)  row currently being filled
- col_idx  out  $clog2(WIDTH/2)  next pair index within the row
- frame_done  out  1  one-cycle pulse after the last pair of a frame
- frame_sum  out  24  modular byte checksum (optional feature)

Behaviour:
- Reset (HRESETn low at a HCLK edge):
  - State goes to IDLE.
  - All registered outputs, counters and data registers are cleared to 0.
  - This applies mid-frame as well; no frame_done is produced.
- FSM states: IDLE, ACTIVE, HBLANK, DONE.
- IDLE:
  - in_ready=0, hsync=0.
  - start=1 and abort=0 -> ACTIVE; row_idx and col_idx cleared.
- ACTIVE:
  - in_ready = !abort (combinational); all other outputs are registered.
  - Accept condition: in_valid & in_ready.
  - On accept, the pair is registered onto DATA_WRITE_*, and hsync=1 in the next cycle (latency 1).
  - Without an accept, hsync=0 next cycle and the data outputs hold their value.
- Column and row counting, on each accept:
  - col_idx < WIDTH/2-1: col_idx increments.
  - col_idx == WIDTH/2-1: col_idx wraps to 0, then:
    - row_idx == HEIGHT-1 -> DONE;
    - otherwise row_idx increments and the state goes to HBLANK (or stays in ACTIVE if HBLANK==0).
- HBLANK:
  - in_ready=0.
  - The blank counter runs for exactly HBLANK cycles, then the state returns to ACTIVE.
- DONE:
  - Lasts one cycle; the last hsync is emitted during this cycle.
  - Then IDLE, with frame_done=1 in the first IDLE cycle.
  - busy falls in that same cycle.
- abort=1 in ACTIVE, HBLANK or DONE:
  - Next state is IDLE; counters are cleared; hsync=0 next cycle; no frame_done.
  - An in_valid in the abort cycle is not accepted, because in_ready is 0.
- start outside IDLE is ignored. start and abort together in IDLE: stay in IDLE.
- Beats per frame = WIDTH/2*HEIGHT.
- Cycles from the first accept to the last accept, with valid held high = beats-1 + (HEIGHT-1)*HBLANK.
- Counter widths:
  - Blank counter: $clog2(HBLANK+1), minimum 1.
  - All counters wrap naturally only via the rules above; no counter ever exceeds its bound.

Optional Feature:
- Macro: IMG_WR_CTRL_SUM_EN.
- With the macro defined:
  - frame_sum is cleared on a start that is accepted.
  - On each accept, it adds all six bytes modulo 2^24.
  - It holds its value from frame_done until the next accepted start.
  - It is cleared on reset and on abort.
- Without the macro: frame_sum is tied to 0 and no adder logic is built.

Decomposition:
- Shared package img_pkg holds:
  - the state enum (IDLE/ACTIVE/HBLANK/DONE);
  - the rgb888_t typedef ({r,g,b} 8-bit each);
  - the BMP_HEADER_NUM=54 constant;
  - the default WIDTH/HEIGHT constants.
- One sub-module, img_raster_cnt: column/row counters with wrap and last-pixel flags, driven by an advance enable and a clear.

Test Plan (WIDTH=8, HEIGHT=4, HBLANK=3 unless noted):
- Continuous valid, start sampled at cycle 0:
  - accepts occur at cycles 1-4, 8-11, 15-18 and 22-25;
  - hsync is high at cycles 2-5, 9-12, 16-19 and 23-26;
  - frame_done is high only at cycle 27.
- Random in_valid bubbles:
  - exactly 16 hsync pulses;
  - DATA_WRITE bytes match the input pairs in order;
  - no hsync during HBLANK;
  - row_idx/col_idx track the accepts.
- abort at the 6th accept cycle:
  - that pair is not accepted; IDLE next cycle; no frame_done;
  - a new start yields a full 16-beat frame beginning at row 0, column 0.
- HRESETn low for 1 cycle during row 2:
  - all outputs are 0 and busy=0 the next cycle;
  - start afterwards gives a correct full frame.
- HBLANK=0, with start pulsed mid-frame:
  - 16 accepts occur back-to-back;
  - the extra start has no effect;
  - frame_done comes 2 cycles after the last accept.
- IMG_WR_CTRL_SUM_EN defined, every byte = 8'h01:
  - frame_sum = 96 when frame_done is high;
  - the value holds until the next start.

Source files
------------

// File: rtl/img_pkg.sv
// Shared types and constants for the image write controller.
//   state_e   : frame sequencer states
//   rgb888_t  : one pixel as {r, g, b}, 8 bits each
//   clog2_min1: $clog2 clamped to at least 1 bit for counter widths
package img_pkg;

    localparam int unsigned BMP_HEADER_NUM = 54;
    localparam int unsigned DEFAULT_WIDTH  = 768;
    localparam int unsigned DEFAULT_HEIGHT = 512;

    typedef enum logic [1:0] {
        StIdle,
        StActive,
        StHblank,
        StDone
    } state_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/image_write_ctrl_if.sv
// Pixel-pair stream from the processing pipeline into the write controller.
//   in_valid : upstream pair valid
//   in_ready : controller accepts the pair this cycle
//   in_pix0  : even pixel {r, g, b}
//   in_pix1  : odd pixel {r, g, b}
// master = upstream producer, slave = controller.
interface image_write_ctrl_if;
    import img_pkg::*;

    logic    in_valid;
    logic    in_ready;
    rgb888_t in_pix0;
    rgb888_t in_pix1;

    modport master (output in_valid, output in_pix0, output in_pix1, input in_ready);
    modport slave  (input in_valid, input in_pix0, input in_pix1, output in_ready);

endinterface

// File: rtl/img_raster_cnt.sv
// Column/row raster counters for the image write controller.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : return both counters to 0
//   adv        : one pixel pair consumed; step column, wrap into next row
//   col_idx    : pair index within the row, 0 .. WIDTH/2-1
//   row_idx    : row index, 0 .. HEIGHT-1
//   col_last   : col_idx is the last pair of the row
//   row_last   : row_idx is the last row of the frame
module img_raster_cnt
    import img_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned HEIGHT = DEFAULT_HEIGHT
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               clr,
    input  logic                               adv,
    output logic [clog2_min1(WIDTH/2)-1:0]     col_idx,
    output logic [clog2_min1(HEIGHT)-1:0]      row_idx,
    output logic                               col_last,
    output logic                               row_last
);

    localparam int unsigned ColW = clog2_min1(WIDTH / 2);
    localparam int unsigned RowW = clog2_min1(HEIGHT);
    localparam logic [ColW-1:0] ColMax = ColW'(WIDTH / 2 - 1);
    localparam logic [RowW-1:0] RowMax = RowW'(HEIGHT - 1);

    logic [ColW-1:0] col_q;
    logic [RowW-1:0] row_q;

    assign col_last = (col_q == ColMax);
    assign row_last = (row_q == RowMax);
    assign col_idx  = col_q;
    assign row_idx  = row_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            col_q <= '0;
            row_q <= '0;
        end else if (adv) begin
            if (col_last) begin
                col_q <= '0;
                // The last row wraps to 0 so the counter never leaves its range.
                row_q <= row_last ? '0 : row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/image_write_ctrl.sv
// Frame sequencer in front of the BMP image writer.
// Accepts RGB888 pixel pairs over a valid/ready stream and replays them to the writer as an
// hsync strobe plus six data bytes, one cycle after acceptance, in raster order. Inserts HBLANK
// idle cycles between rows and supports start/abort of a frame.
//   HCLK, HRESETn       : clock, synchronous active-low reset
//   start, abort        : begin a frame (IDLE only) / abandon the current frame
//   pix                 : pixel-pair stream (slave side)
//   hsync               : one pair is valid on DATA_WRITE_*
//   DATA_WRITE_{R,G,B}0 : pixel 0 bytes;  DATA_WRITE_{R,G,B}1 : pixel 1 bytes
//   busy                : high outside IDLE
//   row_idx, col_idx    : row being filled, next pair index within the row
//   frame_done          : one-cycle pulse in the first IDLE cycle after a complete frame
//   frame_sum           : modular byte checksum of the frame
// Optional feature: define IMG_WR_CTRL_SUM_EN to build the frame_sum adder; otherwise frame_sum
// is tied to 0.
module image_write_ctrl
    import img_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned HEIGHT = DEFAULT_HEIGHT,
    parameter int unsigned HBLANK = 160
) (
    input  logic                               HCLK,
    input  logic                               HRESETn,
    input  logic                               start,
    input  logic                               abort,
    image_write_ctrl_if.slave                  pix,
    output logic                               hsync,
    output logic [7:0]                         DATA_WRITE_R0,
    output logic [7:0]                         DATA_WRITE_G0,
    output logic [7:0]                         DATA_WRITE_B0,
    output logic [7:0]                         DATA_WRITE_R1,
    output logic [7:0]                         DATA_WRITE_G1,
    output logic [7:0]                         DATA_WRITE_B1,
    output logic                               busy,
    output logic [clog2_min1(HEIGHT)-1:0]      row_idx,
    output logic [clog2_min1(WIDTH/2)-1:0]     col_idx,
    output logic                               frame_done,
    output logic [23:0]                        frame_sum
);

    localparam int unsigned BlankW = clog2_min1(HBLANK + 1);
    localparam logic [BlankW-1:0] BlankLast = BlankW'((HBLANK > 0) ? HBLANK - 1 : 0);

    state_e            state_q, state_d;
    logic [BlankW-1:0] blank_q, blank_d;
    logic              hsync_q;
    logic              done_q;
    rgb888_t           pix0_q, pix1_q;

    logic accept;
    logic abort_hit;
    logic start_ok;
    logic cnt_clr;
    logic col_last;
    logic row_last;

    assign accept    = pix.in_valid & pix.in_ready;
    assign abort_hit = abort & (state_q != StIdle);

    img_raster_cnt #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_raster_cnt (
        .clk      (HCLK),
        .rst_n    (HRESETn),
        .clr      (cnt_clr),
        .adv      (accept),
        .col_idx  (col_idx),
        .row_idx  (row_idx),
        .col_last (col_last),
        .row_last (row_last)
    );

    always_comb begin
        state_d      = state_q;
        blank_d      = blank_q;
        pix.in_ready = 1'b0;
        cnt_clr      = 1'b0;
        start_ok     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    state_d  = StActive;
                    cnt_clr  = 1'b1;
                    start_ok = 1'b1;
                end
            end
            StActive: begin
                pix.in_ready = !abort;
                if (pix.in_valid && !abort && col_last) begin
                    if (row_last) begin
                        state_d = StDone;
                    end else if (HBLANK != 0) begin
                        state_d = StHblank;
                        blank_d = '0;
                    end
                end
            end
            StHblank: begin
                if (blank_q == BlankLast) begin
                    state_d = StActive;
                    blank_d = '0;
                end else begin
                    blank_d = blank_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (abort_hit) begin
            state_d = StIdle;
            blank_d = '0;
            cnt_clr = 1'b1;
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q <= StIdle;
            blank_q <= '0;
            hsync_q <= 1'b0;
            done_q  <= 1'b0;
            pix0_q  <= '0;
            pix1_q  <= '0;
        end else begin
            state_q <= state_d;
            blank_q <= blank_d;
            hsync_q <= accept;
            // An aborted DONE cycle must not report a completed frame.
            done_q  <= (state_q == StDone) && !abort;
            if (accept) begin
                pix0_q <= pix.in_pix0;
                pix1_q <= pix.in_pix1;
            end
        end
    end

    assign hsync         = hsync_q;
    assign frame_done    = done_q;
    assign busy          = (state_q != StIdle);
    assign DATA_WRITE_R0 = pix0_q.r;
    assign DATA_WRITE_G0 = pix0_q.g;
    assign DATA_WRITE_B0 = pix0_q.b;
    assign DATA_WRITE_R1 = pix1_q.r;
    assign DATA_WRITE_G1 = pix1_q.g;
    assign DATA_WRITE_B1 = pix1_q.b;

`ifdef IMG_WR_CTRL_SUM_EN
    logic [23:0] sum_q;
    logic [23:0] pair_sum;

    assign pair_sum = 24'(pix.in_pix0.r) + 24'(pix.in_pix0.g) + 24'(pix.in_pix0.b)
                    + 24'(pix.in_pix1.r) + 24'(pix.in_pix1.g) + 24'(pix.in_pix1.b);

    // Holds after frame_done until the next accepted start.
    always_ff @(posedge HCLK) begin
        if (!HRESETn || start_ok || abort_hit) begin
            sum_q <= '0;
        end else if (accept) begin
            sum_q <= sum_q + pair_sum;
        end
    end

    assign frame_sum = sum_q;
`else
    assign frame_sum = '0;
`endif

endmodule
